// File: rtl/cpu_run_ctrl_pkg.sv
// Shared codes for the CPU run/halt sequencer: command ops, stop causes,
// controller states and the MIPS BREAK encoding.
package cpu_run_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_HALT  = 2'b00,
      OP_RUN   = 2'b01,
      OP_STEP  = 2'b10,
      OP_RUN_N = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      CAUSE_HOST  = 2'b00,
      CAUSE_COUNT = 2'b01,
      CAUSE_BREAK = 2'b10,
      CAUSE_BP    = 2'b11
   } cause_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_CNT  = 2'b10
   } state_e;

   localparam logic [5:0] BRK_OPCODE = 6'h00;
   localparam logic [5:0] BRK_FUNCT  = 6'h0D;

endpackage

// File: rtl/cpu_run_ctrl_break_detect.sv
// Combinational stop detection: BREAK instruction or PC breakpoint, masked by
// the skip flag so a resume can step over the instruction that stopped it.
module break_detect
   import cpu_run_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic        bp_en,
   input  logic [31:0] bp_addr,
   input  logic        skip,
   output logic        brk,
   output logic        bph,
   output logic        hit
);

   assign brk = (instr[31:26] == BRK_OPCODE) && (instr[5:0] == BRK_FUNCT);
   assign bph = bp_en && (pc == bp_addr);
   assign hit = (brk || bph) && !skip;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer for the single-cycle MIPS core: gates CPU state update
// and stops on host HALT, budget exhaustion, BREAK or address breakpoint.
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int AUTO_RUN_N = 0
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [31:0]      pc,
   input  logic [31:0]      instr,
   input  logic             bp_en,
   input  logic [31:0]      bp_addr,
   output logic             cpu_en,
   output logic             halted,
   output logic             done,
   output logic [1:0]       stop_cause,
   output logic             cmd_err,
   output logic [CNT_W-1:0] cycles_run
);

   localparam state_e           RST_STATE  = (AUTO_RUN_N != 0) ? ST_CNT : ST_IDLE;
   localparam logic [CNT_W-1:0] RST_REMAIN = CNT_W'(AUTO_RUN_N);

   state_e           state_q, state_d;
   cause_e           cause_q, cause_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic [CNT_W-1:0] cycles_d;
   logic             skip_q, skip_d;
   logic             done_d, err_d;
   logic             brk, bph, hit;
   op_e              op;

   assign op        = op_e'(cmd_op);
   assign cmd_ready = 1'b1;
   assign halted    = (state_q == ST_IDLE);
   assign stop_cause = cause_q;
   // Reset is folded in so an auto-run controller never enables the core while held in reset.
   assign cpu_en    = rst_n && (state_q != ST_IDLE) && !hit;

   break_detect u_break_detect (
      .instr   (instr),
      .pc      (pc),
      .bp_en   (bp_en),
      .bp_addr (bp_addr),
      .skip    (skip_q),
      .brk     (brk),
      .bph     (bph),
      .hit     (hit)
   );

   always_comb begin
      // NOTE: every signal gets a default here so no path infers a latch.
      state_d  = state_q;
      cause_d  = cause_q;
      remain_d = remain_q;
      cycles_d = cycles_run;
      skip_d   = skip_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && op != OP_HALT) begin
               cycles_d = '0;
               skip_d   = 1'b1;
               case (op)
                  OP_RUN:  state_d = ST_RUN;
                  OP_STEP: begin
                     state_d  = ST_CNT;
                     remain_d = CNT_W'(1);
                  end
                  OP_RUN_N: begin
                     if (cmd_count == '0) begin
                        done_d  = 1'b1;
                        cause_d = CAUSE_COUNT;
                     end else begin
                        state_d  = ST_CNT;
                        remain_d = cmd_count;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: begin
            err_d  = cmd_valid && (op != OP_HALT);
            skip_d = 1'b0;
            if (cpu_en) begin
               if (cycles_run != '1) cycles_d = cycles_run + 1'b1;
               if (state_q == ST_CNT) remain_d = remain_q - 1'b1;
            end
            // Same-cycle stop priority: hit, then budget, then host.
            if (hit) begin
               state_d = ST_IDLE;
               cause_d = brk ? CAUSE_BREAK : CAUSE_BP;
               done_d  = 1'b1;
            end else if (state_q == ST_CNT && cpu_en && remain_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               cause_d = CAUSE_COUNT;
               done_d  = 1'b1;
            end else if (cmd_valid && op == OP_HALT) begin
               state_d = ST_IDLE;
               cause_d = CAUSE_HOST;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RST_STATE;
         remain_q   <= RST_REMAIN;
         cause_q    <= CAUSE_HOST;
         cycles_run <= '0;
         skip_q     <= 1'b0;
         done       <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         state_q    <= state_d;
         remain_q   <= remain_d;
         cause_q    <= cause_d;
         cycles_run <= cycles_d;
         skip_q     <= skip_d;
         done       <= done_d;
         cmd_err    <= err_d;
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus randomized
// commands/programs compared against a behavioural run/halt model.
module tb_cpu_run_ctrl;

   localparam int CW = 32;
   localparam logic [1:0] HALT = 2'b00, RUN = 2'b01, STEP = 2'b10, RUN_N = 2'b11;
   localparam longint CYC_MAX = (64'd1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          cmd_valid = 1'b0;
   logic [1:0]    cmd_op = 2'b00;
   logic [CW-1:0] cmd_count = '0;
   logic [31:0]   pc = 32'h0, pc_a = 32'h0;
   logic [31:0]   instr, instr_a;
   logic          bp_en = 1'b0;
   logic [31:0]   bp_addr = 32'h0;
   logic [31:0]   imem [64];

   logic          cmd_ready, cpu_en, halted, done, cmd_err;
   logic [1:0]    stop_cause;
   logic [CW-1:0] cycles_run;
   logic          cmd_ready_a, cpu_en_a, halted_a, done_a, cmd_err_a;
   logic [1:0]    stop_cause_a;
   logic [CW-1:0] cycles_run_a;

   assign instr   = imem[pc[7:2]];
   assign instr_a = 32'h0000_0000;

   cpu_run_ctrl #(.CNT_W(CW), .AUTO_RUN_N(0)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_count(cmd_count), .pc(pc), .instr(instr),
      .bp_en(bp_en), .bp_addr(bp_addr), .cpu_en(cpu_en), .halted(halted),
      .done(done), .stop_cause(stop_cause), .cmd_err(cmd_err), .cycles_run(cycles_run)
   );

   cpu_run_ctrl #(.CNT_W(CW), .AUTO_RUN_N(7)) dut_auto (
      .clk(clk), .rst_n(rst_n), .cmd_valid(1'b0), .cmd_ready(cmd_ready_a),
      .cmd_op(2'b00), .cmd_count('0), .pc(pc_a), .instr(instr_a),
      .bp_en(1'b0), .bp_addr(32'h0), .cpu_en(cpu_en_a), .halted(halted_a),
      .done(done_a), .stop_cause(stop_cause_a), .cmd_err(cmd_err_a), .cycles_run(cycles_run_a)
   );

   int tests_run = 0;
   int failed = 0;

   // Behavioural model: mode 0 = idle, 1 = free run, 2 = budgeted run.
   int     m_mode = 0;
   longint m_left = 0;
   longint m_cyc = 0;
   bit     m_fresh = 0;
   int     m_cause = 0;
   bit     m_done = 0, m_err = 0;
   bit     exp_en = 0, obs_en = 0, obs_en_a = 0;

   task automatic model_reset();
      m_mode = 0; m_left = 0; m_cyc = 0; m_fresh = 0;
      m_cause = 0; m_done = 0; m_err = 0;
   endtask

   // One clock cycle: drive command at negedge, sample cpu_en, advance CPU stubs and model.
   task automatic tick(input bit v, input logic [1:0] op, input logic [31:0] cnt);
      bit brk, bph, hit;
      longint prev_left;
      cmd_valid = v; cmd_op = op; cmd_count = cnt;
      #1;
      brk = (instr[31:26] == 6'd0) && (instr[5:0] == 6'd13);
      bph = bp_en && (pc == bp_addr);
      hit = (brk || bph) && !m_fresh;
      exp_en = (m_mode != 0) && !hit;
      obs_en = cpu_en;
      obs_en_a = cpu_en_a;
      @(posedge clk);
      #1;
      if (obs_en) pc = (pc + 32'd4) & 32'hFF;
      if (obs_en_a) pc_a = pc_a + 32'd4;
      cmd_valid = 1'b0;
      m_done = 0;
      if (m_mode == 0) begin
         m_err = 0;
         if (v && op != HALT) begin
            m_cyc = 0;
            m_fresh = 1;
            if (op == RUN) m_mode = 1;
            else if (op == STEP) begin m_mode = 2; m_left = 1; end
            else if (cnt == 0) begin m_done = 1; m_cause = 1; end
            else begin m_mode = 2; m_left = cnt; end
         end
      end else begin
         m_err = v && (op != HALT);
         prev_left = m_left;
         if (exp_en) begin
            if (m_cyc < CYC_MAX) m_cyc++;
            if (m_mode == 2) m_left--;
         end
         m_fresh = 0;
         if (hit) begin m_mode = 0; m_cause = brk ? 2 : 3; m_done = 1; end
         else if (m_mode == 2 && exp_en && prev_left == 1) begin m_mode = 0; m_cause = 1; m_done = 1; end
         else if (v && op == HALT) begin m_mode = 0; m_cause = 0; m_done = 1; end
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      pc = 32'h0; pc_a = 32'h0;
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic clear_program();
      for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0000;
   endtask

   task automatic test_reset();
      clear_program();
      apply_reset();
      tests_run++;
      if (halted !== 1'b1 || stop_cause !== 2'b00 || cycles_run !== '0 || done !== 1'b0 || cmd_err !== 1'b0) begin
         failed++;
         $display("FAIL reset_values: halted=%b cause=%b cycles=%0d done=%b err=%b, want 1 00 0 0 0",
                  halted, stop_cause, cycles_run, done, cmd_err);
      end
      tests_run++;
      if (cmd_ready !== 1'b1) begin failed++; $display("FAIL cmd_ready: got %b want 1", cmd_ready); end
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, HALT, 0);
         tests_run++;
         if (obs_en !== 1'b0 || halted !== 1'b1) begin
            failed++;
            $display("FAIL idle_cycle%0d: cpu_en=%b halted=%b want 0 1", i, obs_en, halted);
         end
      end
      tests_run++;
      if (pc !== 32'h0) begin failed++; $display("FAIL idle_pc: got %h want 00000000", pc); end
   endtask

   task automatic test_run_n();
      int n_en = 0;
      int n_done = 0;
      pc = 32'h0;
      tick(1'b1, RUN_N, 5);
      for (int i = 0; i < 20 && !halted; i++) begin
         tick(1'b0, HALT, 0);
         n_en += int'(obs_en);
         n_done += int'(done);
      end
      tests_run++;
      if (n_en != 5 || pc !== 32'h14) begin
         failed++; $display("FAIL run_n5: en_cycles=%0d pc=%h want 5 00000014", n_en, pc);
      end
      tests_run++;
      if (n_done != 1 || done !== 1'b1 || stop_cause !== 2'b01 || cycles_run !== 32'd5) begin
         failed++;
         $display("FAIL run_n5_status: done_pulses=%0d done=%b cause=%b cycles=%0d want 1 1 01 5",
                  n_done, done, stop_cause, cycles_run);
      end
      tick(1'b0, HALT, 0);
      tests_run++;
      if (done !== 1'b0) begin failed++; $display("FAIL done_one_cycle: got %b want 0", done); end
   endtask

   task automatic test_break();
      clear_program();
      imem[3] = 32'h0000_000D;
      pc = 32'h0;
      tick(1'b1, RUN, 0);
      for (int i = 0; i < 20 && !halted; i++) tick(1'b0, HALT, 0);
      tests_run++;
      if (pc !== 32'h0C || stop_cause !== 2'b10 || cycles_run !== 32'd3 || !halted) begin
         failed++;
         $display("FAIL break_stop: pc=%h cause=%b cycles=%0d halted=%b want 0000000c 10 3 1",
                  pc, stop_cause, cycles_run, halted);
      end
      tick(1'b1, STEP, 0);
      for (int i = 0; i < 5 && !halted; i++) tick(1'b0, HALT, 0);
      tests_run++;
      if (pc !== 32'h10 || stop_cause !== 2'b01 || cycles_run !== 32'd1 || !halted) begin
         failed++;
         $display("FAIL break_step: pc=%h cause=%b cycles=%0d halted=%b want 00000010 01 1 1",
                  pc, stop_cause, cycles_run, halted);
      end
   endtask

   task automatic test_breakpoint();
      clear_program();
      pc = 32'h0;
      bp_en = 1'b1; bp_addr = 32'h08;
      tick(1'b1, RUN, 0);
      for (int i = 0; i < 20 && !halted; i++) tick(1'b0, HALT, 0);
      tests_run++;
      if (pc !== 32'h08 || stop_cause !== 2'b11 || !halted) begin
         failed++; $display("FAIL bp_stop: pc=%h cause=%b halted=%b want 00000008 11 1", pc, stop_cause, halted);
      end
      tick(1'b1, RUN, 0);
      for (int i = 0; i < 5; i++) tick(1'b0, HALT, 0);
      tests_run++;
      if (pc !== 32'h1C || halted !== 1'b0) begin
         failed++; $display("FAIL bp_resume: pc=%h halted=%b want 0000001c 0", pc, halted);
      end
      tick(1'b1, HALT, 0);
      tests_run++;
      if (obs_en !== 1'b1 || pc !== 32'h20 || halted !== 1'b1 || stop_cause !== 2'b00 || done !== 1'b1) begin
         failed++;
         $display("FAIL host_halt: en=%b pc=%h halted=%b cause=%b done=%b want 1 00000020 1 00 1",
                  obs_en, pc, halted, stop_cause, done);
      end
      tick(1'b0, HALT, 0);
      tests_run++;
      if (obs_en !== 1'b0 || pc !== 32'h20) begin
         failed++; $display("FAIL after_halt: en=%b pc=%h want 0 00000020", obs_en, pc);
      end
      bp_en = 1'b0;
   endtask

   task automatic test_cmd_err();
      tick(1'b1, RUN, 0);
      tick(1'b0, HALT, 0);
      tick(1'b1, STEP, 0);
      tests_run++;
      if (cmd_err !== 1'b1 || halted !== 1'b0) begin
         failed++; $display("FAIL cmd_err_pulse: err=%b halted=%b want 1 0", cmd_err, halted);
      end
      tick(1'b0, HALT, 0);
      tests_run++;
      if (cmd_err !== 1'b0 || halted !== 1'b0 || obs_en !== 1'b1) begin
         failed++; $display("FAIL cmd_err_clear: err=%b halted=%b en=%b want 0 0 1", cmd_err, halted, obs_en);
      end
      tick(1'b1, HALT, 0);
      tick(1'b1, RUN_N, 0);
      tests_run++;
      if (done !== 1'b1 || stop_cause !== 2'b01 || halted !== 1'b1 || obs_en !== 1'b0) begin
         failed++;
         $display("FAIL run_n0: done=%b cause=%b halted=%b en=%b want 1 01 1 0", done, stop_cause, halted, obs_en);
      end
      tick(1'b0, HALT, 0);
      tests_run++;
      if (obs_en !== 1'b0 || done !== 1'b0) begin
         failed++; $display("FAIL run_n0_after: en=%b done=%b want 0 0", obs_en, done);
      end
   endtask

   task automatic test_reset_mid_run();
      int n_en_a = 0;
      int n_done_a = 0;
      tick(1'b1, RUN_N, 100);
      for (int i = 0; i < 10; i++) tick(1'b0, HALT, 0);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (cpu_en !== 1'b0 || halted !== 1'b1 || cycles_run !== '0 || stop_cause !== 2'b00 || done !== 1'b0 || cmd_err !== 1'b0) begin
         failed++;
         $display("FAIL async_reset: en=%b halted=%b cycles=%0d cause=%b done=%b err=%b want 0 1 0 00 0 0",
                  cpu_en, halted, cycles_run, stop_cause, done, cmd_err);
      end
      tests_run++;
      if (cpu_en_a !== 1'b0 || halted_a !== 1'b0 || cycles_run_a !== '0) begin
         failed++;
         $display("FAIL auto_in_reset: en=%b halted=%b cycles=%0d want 0 0 0", cpu_en_a, halted_a, cycles_run_a);
      end
      @(negedge clk);
      pc = 32'h0; pc_a = 32'h0;
      model_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, HALT, 0);
         n_en_a += int'(obs_en_a);
         n_done_a += int'(done_a);
      end
      tests_run++;
      if (n_en_a != 7 || pc_a !== 32'd28 || n_done_a != 1) begin
         failed++; $display("FAIL auto_run7: en_cycles=%0d pc=%h done_pulses=%0d want 7 0000001c 1", n_en_a, pc_a, n_done_a);
      end
      tests_run++;
      if (halted_a !== 1'b1 || stop_cause_a !== 2'b01 || cycles_run_a !== 32'd7) begin
         failed++;
         $display("FAIL auto_status: halted=%b cause=%b cycles=%0d want 1 01 7", halted_a, stop_cause_a, cycles_run_a);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 64; i++) begin
         case ($urandom_range(0, 7))
            0:       imem[i] = 32'h0000_000D;
            1:       imem[i] = {6'd0, 20'($urandom), 6'h0D};
            default: imem[i] = $urandom;
         endcase
      end
      for (int t = 0; t < 600; t++) begin
         bit v;
         logic [1:0] op;
         if ($urandom_range(0, 15) == 0) begin
            bp_en = 1'($urandom);
            bp_addr = {24'd0, 6'($urandom), 2'b00};
         end
         v = ($urandom_range(0, 4) == 0);
         op = 2'($urandom);
         tick(v, op, $urandom_range(0, 6));
         tests_run++;
         if (obs_en !== exp_en || halted !== (m_mode == 0) || done !== m_done || cmd_err !== m_err ||
             stop_cause !== 2'(m_cause) || cycles_run !== CW'(m_cyc)) begin
            failed++;
            $display("FAIL random%0d: en=%b/%b halted=%b/%b done=%b/%b err=%b/%b cause=%b/%0d cycles=%0d/%0d (got/want)",
                     t, obs_en, exp_en, halted, (m_mode == 0), done, m_done, cmd_err, m_err,
                     stop_cause, m_cause, cycles_run, m_cyc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_run_n();
      test_break();
      test_breakpoint();
      test_cmd_err();
      test_reset_mid_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
